// File: rtl/pic_stream_ctrl.sv
// Read sequencer for the 28x28 picture RAM: walks addresses, absorbs the RAM read latency
// and streams tagged pixels over valid/ready. Optional binarisation: define THRESH_EN.
module pic_stream_ctrl #(
    parameter int NUM_PIX = 784,
    parameter int IMG_W   = 28,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8,
    parameter int THRESH  = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_data,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_last,
    output logic [4:0]        pix_row,
    output logic [4:0]        pix_col
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);
    localparam logic [4:0]        LAST_COL  = 5'(IMG_W - 1);
    localparam logic [4:0]        LAST_ROW  = 5'(NUM_PIX / IMG_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic                inflight_q, inflight_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   buf0_q, buf0_d;
    logic [DATA_W-1:0]   buf1_q, buf1_d;
    logic [4:0]          row_q, row_d;
    logic [4:0]          col_q, col_d;

    logic                push;
    logic                pop;
    logic                issue;
    logic [2:0]          occ;
    logic [DATA_W-1:0]   in_data;

    function automatic logic [DATA_W-1:0] binarise(input logic [DATA_W-1:0] v);
        return (v >= DATA_W'(THRESH)) ? '1 : '0;
    endfunction

`ifdef THRESH_EN
    assign in_data = binarise(ram_data);
`else
    assign in_data = ram_data;
`endif

    assign pix_valid = (cnt_q != 2'd0);
    assign pop       = pix_valid & pix_ready;
    assign push      = inflight_q;

    always_comb begin
        state_d    = state_q;
        ram_addr_d = ram_addr_q;
        inflight_d = 1'b0;
        cnt_d      = cnt_q;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        row_d      = row_q;
        col_d      = col_q;
        issue      = 1'b0;
        occ        = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

        // Two-entry buffer: buf0 is always the head presented downstream.
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) buf0_d = in_data;
                else               buf1_d = in_data;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd2) begin
                    buf0_d = buf1_q;
                    buf1_d = in_data;
                end else begin
                    buf0_d = in_data;
                end
            end
            default: ;
        endcase

        if (pop) begin
            if (col_q == LAST_COL) begin
                col_d = 5'd0;
                row_d = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
            end else begin
                col_d = col_q + 5'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_FETCH;
                    ram_addr_d = '0;
                    row_d      = 5'd0;
                    col_d      = 5'd0;
                end
            end
            S_FETCH: begin
                // Only issue when the read is guaranteed a buffer slot on arrival.
                issue = (occ < 3'd2);
                if (issue) begin
                    inflight_d = 1'b1;
                    if (ram_addr_q == LAST_ADDR) state_d = S_DRAIN;
                    else                         ram_addr_d = ram_addr_q + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_d == 2'd0 && !inflight_q) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ram_addr_q <= '0;
            inflight_q <= 1'b0;
            cnt_q      <= 2'd0;
            row_q      <= 5'd0;
            col_q      <= 5'd0;
        end else begin
            state_q    <= state_d;
            ram_addr_q <= ram_addr_d;
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
            row_q      <= row_d;
            col_q      <= col_d;
        end
    end

    always_ff @(posedge clk) begin
        buf0_q <= buf0_d;
        buf1_q <= buf1_d;
    end

    assign busy     = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign done     = (state_q == S_DONE);
    assign ram_addr = ram_addr_q;
    assign pix_data = pix_valid ? buf0_q : '0;
    assign pix_row  = row_q;
    assign pix_col  = col_q;
    assign pix_last = pix_valid && (row_q == LAST_ROW) && (col_q == LAST_COL);

endmodule

// File: doc/pic_stream_ctrl.md
Name: pic_stream_ctrl

Overview:
Read sequencer for the 784-pixel (28x28) picture RAM. On a start pulse it walks the RAM address space 0..NUM_PIX-1 and absorbs the RAM's one-cycle read latency. Pixels stream to the downstream classifier over a valid/ready handshake, with row/column tags and an end-of-frame marker. It sits between pic_ram and the recognition datapath and is the only master of the RAM address bus.

Parameters:
NUM_PIX, 784, pixels per frame
IMG_W, 28, pixels per row
ADDR_W, 10, RAM address width
DATA_W, 8, pixel width
THRESH, 128, binarisation threshold (used only with THRESH_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin frame; sampled only in IDLE
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse after the last pixel handshake
ram_addr  out  ADDR_W  address to pic_ram (registered)
ram_data  in  DATA_W  pic_ram data_out, valid one cycle after ram_addr
pix_data  out  DATA_W  pixel value
pix_valid  out  1  pix_data/tags valid
pix_ready  in  1  downstream accept
pix_last  out  1  high with pixel NUM_PIX-1
pix_row  out  5  row index of current pixel (0..27)
pix_col  out  5  column index of current pixel (0..27)

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset: busy=0, done=0, ram_addr=0, pix_valid=0, pix_last=0, pix_data=0, pix_row=0, pix_col=0; buffer emptied, in-flight read discarded, state IDLE.
- States:
  - IDLE: start=1 moves to FETCH, loads ram_addr=0, issues the first read.
  - FETCH: issues reads while the issue counter < NUM_PIX; when the final address (NUM_PIX-1) has been issued, moves to DRAIN.
  - DRAIN: waits for buffer empty and no read in flight, then moves to DONE.
  - DONE: drives done=1 for exactly one cycle, returns to IDLE, busy=0.
- Handshake: a pixel transfers on any edge with pix_valid & pix_ready. While pix_valid=1 and pix_ready=0, pix_data, pix_last, pix_row and pix_col hold stable. pix_valid never drops without a transfer.
- Buffer: 2-entry output FIFO. A read is issued in a cycle only if (occupancy + in-flight - pop_this_cycle) < 2. This gives no overflow and no lost RAM data.
- Latency: first pix_valid is high 2 cycles after the edge that samples start. With pix_ready held at 1, throughput is 1 pixel/clock with no bubbles.
- Addressing: ram_addr increments by 1 per issued read. It stops at NUM_PIX-1 and never wraps to 784; it holds its value after the last read until the next start, which reloads 0.
- Tags: pix_col increments per delivered pixel and wraps IMG_W-1 -> 0, at which point pix_row increments. Both return to 0 at start. pix_last=1 exactly when the delivered pixel index = NUM_PIX-1.
- done asserts the cycle after the last-pixel handshake edge; busy falls in the same cycle done pulses.
- start while busy is ignored, with no restart or counter disturbance.
- Reset asserted mid-frame: all outputs take reset values on the next edge; the next start begins cleanly at address 0.
- If pix_ready is held at 0 indefinitely, the block stalls with at most 2 buffered pixels and no further reads.

Optional Feature:
THRESH_EN
- Defined: pix_data = (ram_data >= THRESH) ? all-ones : 0, registered with the data entering the buffer; latency unchanged.
- Undefined: pix_data is the raw RAM value; THRESH is unused.

Test Plan:
- RAM model mem[i]=i[7:0], pix_ready=1, single start: 784 transfers on consecutive cycles with pix_data=0,1,..,255,0,..; first valid 2 cycles after start; pix_last only on the 784th transfer (data 0x0F); done 1 cycle later; busy then 0.
- pix_ready random 50% duty: exactly 784 transfers in order with no duplicates or drops; pix_data is stable across every stalled cycle; ram_addr never exceeds 783.
- Tag check: transfer 29 (index 28) reports row=1, col=0; index 783 reports row=27, col=27.
- Start pulse asserted again at pixel 100: ignored; stream continues 101..783; exactly one done.
- rst for 1 cycle after transfer 300: next cycle all outputs are 0 and state is IDLE. New start streams from index 0 and completes all 784 pixels.
- THRESH_EN defined, mem values 127 and 128 at indices 0 and 1: pix_data = 0x00 then 0xFF.
